// File: rtl/sim_run_controller_if.sv
// Host command channel for sim_run_controller: valid/ready handshake carrying
// an opcode and a cycle budget.
interface sim_run_controller_if #(
    parameter int CYCLE_WIDTH = 32
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [CYCLE_WIDTH-1:0] cmd_cycles;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_cycles,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_cycles,
        output cmd_ready
    );
endinterface

// File: rtl/sim_run_controller.sv
// Simulator run controller: sequences sim_enable from host START/PAUSE/RESUME/STEP
// commands and counts simulated cycles against the latched budget.
module sim_run_controller #(
    parameter int CYCLE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    sim_run_controller_if.slave    cmd,
    output logic                   sim_enable,
    output logic [CYCLE_WIDTH-1:0] sim_cycle,
    output logic [2:0]             state,
    output logic                   done,
    output logic                   cmd_err
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_STEP  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        OP_START  = 2'd0,
        OP_PAUSE  = 2'd1,
        OP_RESUME = 2'd2,
        OP_STEP   = 2'd3
    } op_e;

    state_e                 state_q, state_d;
    logic [CYCLE_WIDTH-1:0] budget_q, budget_d;
    logic [CYCLE_WIDTH-1:0] sim_cycle_q, sim_cycle_d;
    logic                   done_q, done_d;
    logic                   cmd_err_q, cmd_err_d;

    op_e  op;
    logic accept;
    logic last_cycle;

    assign op            = op_e'(cmd.cmd_op);
    assign cmd.cmd_ready = (state_q != ST_INIT) && (state_q != ST_STEP);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign sim_enable    = (state_q == ST_RUN) || (state_q == ST_STEP);
    // Only evaluated while enabled, so budget_q is never 0 here and cannot underflow.
    assign last_cycle    = sim_enable && (sim_cycle_q == budget_q - CYCLE_WIDTH'(1));

    always_comb begin
        state_d     = state_q;
        budget_d    = budget_q;
        sim_cycle_d = sim_cycle_q;
        cmd_err_d   = 1'b0;

        if (sim_enable) begin
            sim_cycle_d = sim_cycle_q + CYCLE_WIDTH'(1);
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if (op == OP_START) begin
                        state_d     = ST_INIT;
                        budget_d    = cmd.cmd_cycles;
                        sim_cycle_d = '0;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ST_INIT: begin
                state_d = (budget_q != '0) ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                // Completion wins over a same-cycle PAUSE, which is silently dropped.
                if (last_cycle) begin
                    state_d = ST_DONE;
                end else if (accept && op == OP_PAUSE) begin
                    state_d = ST_PAUSE;
                end
                if (accept && op != OP_PAUSE) begin
                    cmd_err_d = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (accept) begin
                    unique case (op)
                        OP_RESUME: state_d   = ST_RUN;
                        OP_STEP:   state_d   = ST_STEP;
                        default:   cmd_err_d = 1'b1;
                    endcase
                end
            end
            ST_STEP: begin
                state_d = last_cycle ? ST_DONE : ST_PAUSE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            budget_q    <= '0;
            sim_cycle_q <= '0;
            done_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            budget_q    <= budget_d;
            sim_cycle_q <= sim_cycle_d;
            done_q      <= done_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign state     = state_q;
    assign sim_cycle = sim_cycle_q;
    assign done      = done_q;
    assign cmd_err   = cmd_err_q;
endmodule

// File: tb/tb_sim_run_controller.sv
// Scoreboard bench for sim_run_controller: stimulus pushes per-cycle expected
// snapshots, a negedge monitor pops and compares those due in the current cycle.
module tb_sim_run_controller;
  localparam int W = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_STEP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0] OP_START  = 2'd0;
  localparam logic [1:0] OP_PAUSE  = 2'd1;
  localparam logic [1:0] OP_RESUME = 2'd2;
  localparam logic [1:0] OP_STEP   = 2'd3;

  logic         clk;
  logic         reset;
  logic         sim_enable;
  logic [W-1:0] sim_cycle;
  logic [2:0]   state;
  logic         done;
  logic         cmd_err;

  sim_run_controller_if #(.CYCLE_WIDTH(W)) cmd_if ();

  sim_run_controller #(.CYCLE_WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd_if),
    .sim_enable (sim_enable),
    .sim_cycle  (sim_cycle),
    .state      (state),
    .done       (done),
    .cmd_err    (cmd_err)
  );

  typedef struct {
    int           cyc;
    string        nm;
    logic [2:0]   st;
    logic         en;
    logic [W-1:0] sc;
    logic         dn;
    logic         er;
    logic         rdy;
  } exp_t;

  exp_t sbq[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: timeout at cyc %0d, required run to complete", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void exp_at(input int c, input string nm, input logic [2:0] st,
                                 input logic en, input logic [W-1:0] sc,
                                 input logic dn, input logic er);
    exp_t e;
    e.cyc = c;
    e.nm  = nm;
    e.st  = st;
    e.en  = en;
    e.sc  = sc;
    e.dn  = dn;
    e.er  = er;
    e.rdy = !(st == S_INIT || st == S_STEP);
    sbq.push_back(e);
  endfunction

  // Monitor: compare every snapshot that is due in this cycle.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        n_cmp++;
        if ({state, sim_enable, sim_cycle, done, cmd_err, cmd_if.cmd_ready} !==
            {sbq[i].st, sbq[i].en, sbq[i].sc, sbq[i].dn, sbq[i].er, sbq[i].rdy}) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got st=%0d en=%0b sc=%0d done=%0b err=%0b rdy=%0b, want st=%0d en=%0b sc=%0d done=%0b err=%0b rdy=%0b",
                   sbq[i].nm, cyc, state, sim_enable, sim_cycle, done, cmd_err,
                   cmd_if.cmd_ready, sbq[i].st, sbq[i].en, sbq[i].sc, sbq[i].dn,
                   sbq[i].er, sbq[i].rdy);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a command for exactly one cycle (ready is high in every state we issue from).
  task automatic issue(input logic [1:0] op, input logic [W-1:0] n);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_op     = op;
    cmd_if.cmd_cycles = n;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_op     = 2'd0;
    cmd_if.cmd_cycles = '0;
  endtask

  int t;

  initial begin
    reset             = 1'b1;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_op     = 2'd0;
    cmd_if.cmd_cycles = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (state !== S_IDLE || sim_enable !== 1'b0 || cmd_if.cmd_ready !== 1'b1 ||
        sim_cycle !== '0 || done !== 1'b0 || cmd_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: got st=%0d en=%0b rdy=%0b sc=%0d done=%0b err=%0b, want st=0 en=0 rdy=1 sc=0 done=0 err=0",
               state, sim_enable, cmd_if.cmd_ready, sim_cycle, done, cmd_err);
    end
    exp_at(cyc, "reset", S_IDLE, 1'b0, 8'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // RESUME in IDLE is illegal
    t = cyc;
    exp_at(t,     "idle",            S_IDLE, 1'b0, 8'd0, 1'b0, 1'b0);
    exp_at(t + 1, "err_resume_idle", S_IDLE, 1'b0, 8'd0, 1'b0, 1'b1);
    exp_at(t + 2, "err_resume_clr",  S_IDLE, 1'b0, 8'd0, 1'b0, 1'b0);
    issue(OP_RESUME, 8'd0);
    wait_until(t + 2);

    // START budget 3
    t = cyc;
    exp_at(t + 1, "b3_init", S_INIT, 1'b0, 8'd0, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 3; k++)
      exp_at(t + 2 + k, "b3_run", S_RUN, 1'b1, W'(k), 1'b0, 1'b0);
    exp_at(t + 5, "b3_done", S_DONE, 1'b0, 8'd3, 1'b1, 1'b0);
    exp_at(t + 6, "b3_hold", S_DONE, 1'b0, 8'd3, 1'b0, 1'b0);
    issue(OP_START, 8'd3);
    wait_until(t + 6);

    // START budget 0
    t = cyc;
    exp_at(t + 1, "b0_init", S_INIT, 1'b0, 8'd0, 1'b0, 1'b0);
    exp_at(t + 2, "b0_done", S_DONE, 1'b0, 8'd0, 1'b1, 1'b0);
    exp_at(t + 3, "b0_hold", S_DONE, 1'b0, 8'd0, 1'b0, 1'b0);
    issue(OP_START, 8'd0);
    wait_until(t + 3);

    // Budget 10: STEP in RUN illegal, PAUSE at 4, START in PAUSE illegal, 3 STEPs, RESUME
    t = cyc;
    exp_at(t + 1, "b10_init", S_INIT, 1'b0, 8'd0, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 4; k++)
      exp_at(t + 2 + k, "b10_run", S_RUN, 1'b1, W'(k), 1'b0, (k == 2));
    exp_at(t + 6, "b10_paused",      S_PAUSE, 1'b0, 8'd4, 1'b0, 1'b0);
    exp_at(t + 7, "err_start_pause", S_PAUSE, 1'b0, 8'd4, 1'b0, 1'b1);
    issue(OP_START, 8'd10);
    wait_until(t + 3);
    issue(OP_STEP, 8'd0);
    wait_until(t + 5);
    issue(OP_PAUSE, 8'd0);
    issue(OP_START, 8'd99);
    for (int unsigned s = 0; s < 3; s++) begin
      exp_at(t + 8 + 2 * s, "b10_step",  S_STEP,  1'b1, W'(4 + s), 1'b0, 1'b0);
      exp_at(t + 9 + 2 * s, "b10_after", S_PAUSE, 1'b0, W'(5 + s), 1'b0, 1'b0);
      wait_until(t + 7 + 2 * s);
      issue(OP_STEP, 8'd0);
    end
    for (int unsigned k = 0; k < 3; k++)
      exp_at(t + 14 + k, "b10_resumed", S_RUN, 1'b1, W'(7 + k), 1'b0, 1'b0);
    exp_at(t + 17, "b10_done", S_DONE, 1'b0, 8'd10, 1'b1, 1'b0);
    exp_at(t + 18, "b10_hold", S_DONE, 1'b0, 8'd10, 1'b0, 1'b0);
    wait_until(t + 13);
    issue(OP_RESUME, 8'd0);
    wait_until(t + 18);

    // Budget 2: pause at 1, STEP completes directly to DONE
    t = cyc;
    exp_at(t + 1, "b2_init",  S_INIT,  1'b0, 8'd0, 1'b0, 1'b0);
    exp_at(t + 2, "b2_run",   S_RUN,   1'b1, 8'd0, 1'b0, 1'b0);
    exp_at(t + 3, "b2_pause", S_PAUSE, 1'b0, 8'd1, 1'b0, 1'b0);
    exp_at(t + 4, "b2_step",  S_STEP,  1'b1, 8'd1, 1'b0, 1'b0);
    exp_at(t + 5, "b2_done",  S_DONE,  1'b0, 8'd2, 1'b1, 1'b0);
    exp_at(t + 6, "b2_hold",  S_DONE,  1'b0, 8'd2, 1'b0, 1'b0);
    issue(OP_START, 8'd2);
    wait_until(t + 2);
    issue(OP_PAUSE, 8'd0);
    issue(OP_STEP, 8'd0);
    wait_until(t + 6);

    // PAUSE in DONE is illegal
    t = cyc;
    exp_at(t + 1, "err_pause_done", S_DONE, 1'b0, 8'd2, 1'b0, 1'b1);
    exp_at(t + 2, "err_pause_clr",  S_DONE, 1'b0, 8'd2, 1'b0, 1'b0);
    issue(OP_PAUSE, 8'd0);
    wait_until(t + 2);

    // PAUSE on the final RUN cycle is swallowed by completion
    t = cyc;
    exp_at(t + 1, "lastp_init", S_INIT, 1'b0, 8'd0, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 3; k++)
      exp_at(t + 2 + k, "lastp_run", S_RUN, 1'b1, W'(k), 1'b0, 1'b0);
    exp_at(t + 5, "lastp_done", S_DONE, 1'b0, 8'd3, 1'b1, 1'b0);
    exp_at(t + 6, "lastp_hold", S_DONE, 1'b0, 8'd3, 1'b0, 1'b0);
    issue(OP_START, 8'd3);
    wait_until(t + 4);
    issue(OP_PAUSE, 8'd0);
    wait_until(t + 6);

    // All-ones budget reaches 255 without wrapping
    t = cyc;
    exp_at(t + 1,   "max_init",  S_INIT, 1'b0, 8'd0,   1'b0, 1'b0);
    exp_at(t + 2,   "max_first", S_RUN,  1'b1, 8'd0,   1'b0, 1'b0);
    exp_at(t + 129, "max_mid",   S_RUN,  1'b1, 8'd127, 1'b0, 1'b0);
    exp_at(t + 256, "max_last",  S_RUN,  1'b1, 8'd254, 1'b0, 1'b0);
    exp_at(t + 257, "max_done",  S_DONE, 1'b0, 8'd255, 1'b1, 1'b0);
    exp_at(t + 260, "max_hold",  S_DONE, 1'b0, 8'd255, 1'b0, 1'b0);
    issue(OP_START, 8'd255);
    wait_until(t + 260);

    // Reset mid-RUN at sim_cycle 5, then a budget-1 run
    t = cyc;
    exp_at(t + 1, "rst_init", S_INIT, 1'b0, 8'd0, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 5; k++)
      exp_at(t + 2 + k, "rst_run", S_RUN, 1'b1, W'(k), 1'b0, 1'b0);
    exp_at(t + 7, "rst_abort", S_IDLE, 1'b0, 8'd0, 1'b0, 1'b0);
    issue(OP_START, 8'd8);
    wait_until(t + 7);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (state !== S_IDLE || sim_cycle !== '0 || sim_enable !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_immediate: got st=%0d sc=%0d en=%0b done=%0b, want st=0 sc=0 en=0 done=0",
               state, sim_cycle, sim_enable, done);
    end
    wait_until(t + 8);
    reset = 1'b0;
    t = cyc;
    exp_at(t,     "b1_idle", S_IDLE, 1'b0, 8'd0, 1'b0, 1'b0);
    exp_at(t + 1, "b1_init", S_INIT, 1'b0, 8'd0, 1'b0, 1'b0);
    exp_at(t + 2, "b1_run",  S_RUN,  1'b1, 8'd0, 1'b0, 1'b0);
    exp_at(t + 3, "b1_done", S_DONE, 1'b0, 8'd1, 1'b1, 1'b0);
    exp_at(t + 4, "b1_hold", S_DONE, 1'b0, 8'd1, 1'b0, 1'b0);
    issue(OP_START, 8'd1);
    wait_until(t + 6);
    n_cmp++;
    if (state !== S_DONE || sim_cycle !== 8'd1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL b1_final: got st=%0d sc=%0d done=%0b, want st=5 sc=1 done=0",
               state, sim_cycle, done);
    end

    foreach (sbq[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: snapshot for cyc %0d never compared, required one", sbq[i].nm,
               sbq[i].cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sim_run_controller.md
# sim_run_controller

Run controller for the simulator lifecycle engine. It accepts host commands (start with cycle budget, pause, resume, single-step) over a valid/ready handshake. It sequences the simulated-cycle advance via `sim_enable` and tracks the simulated cycle count against the budget. It reports lifecycle state and flags completion and illegal commands, and sits between the host command interface and the simulator core.

## Interface
- `CYCLE_WIDTH`, default 32: width of the cycle budget and the cycle counter.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `cmd_valid`  in  1: host command present.
- `cmd_ready`  out  1: controller can accept a command this cycle.
- `cmd_op`  in  2: command opcode. 0 = START, 1 = PAUSE, 2 = RESUME, 3 = STEP.
- `cmd_cycles`  in  CYCLE_WIDTH: cycle budget. Sampled only on an accepted START.
- `sim_enable`  out  1: simulated cycle advances this clock.
- `sim_cycle`  out  CYCLE_WIDTH: simulated cycles completed since the last START.
- `state`  out  3: lifecycle state. IDLE = 0, INIT = 1, RUN = 2, PAUSE = 3, STEP = 4, DONE = 5.
- `done`  out  1: one-cycle pulse on the first cycle in DONE.
- `cmd_err`  out  1: one-cycle pulse, registered, the cycle after an illegal command is accepted.

## Operation
- A command is accepted when `cmd_valid && cmd_ready`. `cmd_ready` = 0 in INIT and STEP and 1 in all other states.
- START:
  - Legal in IDLE or DONE. It latches `budget <= cmd_cycles`, clears `sim_cycle`, and moves to INIT.
  - Illegal in RUN or PAUSE; state is unchanged and `cmd_err` pulses.
- INIT lasts exactly one cycle. It moves to RUN if `budget != 0`; otherwise it moves to DONE with no `sim_enable`.
- PAUSE: RUN → PAUSE. Illegal in IDLE, PAUSE and DONE.
- RESUME: PAUSE → RUN. Illegal elsewhere.
- STEP: PAUSE → STEP. STEP lasts exactly one cycle, then returns to PAUSE, or goes to DONE if the budget is reached. Illegal elsewhere.
- `sim_enable` is a combinational decode: 1 when state is RUN or STEP, else 0.
- `sim_cycle` increments by 1 on each clock where `sim_enable` = 1.
- Completion:
  - In RUN or STEP, if `sim_cycle == budget - 1`, the next state is DONE. This cycle is the last enable.
  - `sim_cycle` therefore ends equal to `budget` and never exceeds it.
- Completion has priority over a same-cycle accepted PAUSE. The PAUSE is consumed with no effect and no `cmd_err`.
- DONE holds until a START is accepted. `sim_cycle` and `budget` hold their values in DONE.
- A budget of all-ones is legal. `sim_cycle` reaches all-ones without wrapping.

## Timing
- Reset values: `state` = IDLE, `sim_cycle` = 0, budget = 0, `done` = 0, `cmd_err` = 0.
- Reset values of combinational outputs: `sim_enable` = 0, `cmd_ready` = 1.
- Reset mid-run aborts immediately with no completion pulse.
- START accepted at cycle t:
  - t+1: INIT.
  - t+2: first RUN cycle with `sim_enable` = 1.
  - For budget N ≥ 1, RUN spans t+2 … t+N+1.
  - t+N+2: DONE with `done` = 1 and `sim_cycle` = N.
- Budget 0: INIT at t+1, DONE and `done` pulse at t+2.
- STEP accepted at t: STEP state and `sim_enable` at t+1, back in PAUSE (or DONE) at t+2.
- A command accepted at t changes `state` at t+1. `cmd_err` is high during t+1 only.
- Each `done` pulse is exactly 1 cycle. It re-pulses only after a new START reaches DONE again.

## Test plan
- Reset, then START with `cmd_cycles` = 3 at cycle 0 → INIT at cycle 1; `sim_enable` = 1 during cycles 2–4; DONE and `done` = 1 at cycle 5 with `sim_cycle` = 3; `done` = 0 at cycle 6.
- START with `cmd_cycles` = 0 → INIT then DONE. `sim_enable` is never asserted and `sim_cycle` stays 0.
- Budget 10; PAUSE accepted after `sim_cycle` = 4 → holds at 4. Three STEPs → 7, one enable each, `cmd_ready` low in each STEP cycle. RESUME → DONE with `sim_cycle` = 10.
- Budget 2; pause at 1; STEP → `sim_cycle` = 2 and DONE directly from STEP, `done` pulses.
- Illegal commands (RESUME in IDLE, STEP in RUN, START in PAUSE, PAUSE in DONE) → `cmd_err` pulses one cycle each and state is unchanged.
- PAUSE issued on the final RUN cycle → DONE, no `cmd_err`.
- Assert `reset` mid-RUN at `sim_cycle` = 5 → immediately IDLE with `sim_cycle` = 0 and `sim_enable` = 0. A subsequent START with budget 1 completes normally.
